// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge detector: |Gx|+|Gy| (saturated or thresholded) or centre-pixel bypass.
// Latency: 3 pixel_clk cycles from the sampling edge of the completing sample to out_valid/edge_out.
// Backpressure: none; every cycle's sample is processed as presented, non-active cycles are ignored.
module sobel_edge_filter #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int THRESHOLD = 0
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic [9:0] h_pos,
    input  logic [8:0] v_pos,
    input  logic [7:0] pix_in,
    input  logic       bypass,
    output logic       out_valid,
    output logic [9:0] out_h,
    output logic [8:0] out_v,
    output logic [7:0] edge_out
);
    localparam int          AW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);
    localparam logic [11:0] THR    = 12'(THRESHOLD);
    localparam bit          THR_EN = (THRESHOLD > 0);

    // Input qualification
    logic          active;
    logic          frame_start;
    logic          emit;
    logic [AW-1:0] col_addr;

    // Line buffers: row v-1 and row v-2 of the current column
    logic [7:0] lb_row1 [H_ACTIVE];
    logic [7:0] lb_row2 [H_ACTIVE];
    logic [7:0] rd_row1;
    logic [7:0] rd_row2;
    logic       frame_synced;

    // Stage 1: 3x3 window, index 0 = leftmost column
    logic [2:0][7:0] win_top;
    logic [2:0][7:0] win_mid;
    logic [2:0][7:0] win_bot;
    logic            s1_vld;
    logic            s1_byp;
    logic            s1_border;
    logic [9:0]      s1_h;
    logic [8:0]      s1_v;

    // Stage 2: signed gradients
    logic [9:0]  sum_l;
    logic [9:0]  sum_r;
    logic [9:0]  sum_t;
    logic [9:0]  sum_b;
    logic [10:0] gx_c;
    logic [10:0] gy_c;
    logic        s2_vld;
    logic        s2_byp;
    logic        s2_border;
    logic [9:0]  s2_h;
    logic [8:0]  s2_v;
    logic [7:0]  s2_ctr;
    logic [10:0] s2_gx;
    logic [10:0] s2_gy;

    // Stage 3: unsaturated magnitude
    logic [10:0] abs_gx;
    logic [10:0] abs_gy;
    logic [10:0] mag_c;
    logic        s3_vld;
    logic        s3_byp;
    logic        s3_border;
    logic [9:0]  s3_h;
    logic [8:0]  s3_v;
    logic [7:0]  s3_ctr;
    logic [10:0] s3_mag;

    // Output selection
    logic [7:0] res_c;

    assign active      = ({1'b0, h_pos} < H_LIM) && ({1'b0, v_pos} < V_LIM);
    assign frame_start = active && (h_pos == 10'd0) && (v_pos == 9'd0);
    // Row 0 / column 0 samples cannot complete a window; nothing is emitted before the first frame start
    assign emit        = active && frame_synced && (h_pos != 10'd0) && (v_pos != 9'd0);
    assign col_addr    = h_pos[AW-1:0];
    assign rd_row1     = lb_row1[col_addr];
    assign rd_row2     = lb_row2[col_addr];

    // Line buffers push the column down one row per active sample; no reset, stale data is masked by frame sync
    always_ff @(posedge pixel_clk) begin
        if (active) begin
            lb_row1[col_addr] <= pix_in;
            lb_row2[col_addr] <= rd_row1;
        end
    end

    // Frame sync: arm emission at the first frame start after reset
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_synced <= 1'b0;
        end else if (frame_start) begin
            frame_synced <= 1'b1;
        end
    end

    // Window shift and centre position capture on every active sample
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            win_top   <= '0;
            win_mid   <= '0;
            win_bot   <= '0;
            s1_vld    <= 1'b0;
            s1_byp    <= 1'b0;
            s1_border <= 1'b0;
            s1_h      <= 10'd0;
            s1_v      <= 9'd0;
        end else begin
            s1_vld <= emit;
            if (active) begin
                win_top   <= {rd_row2, win_top[2:1]};
                win_mid   <= {rd_row1, win_mid[2:1]};
                win_bot   <= {pix_in,  win_bot[2:1]};
                s1_byp    <= bypass;
                // Centre on row 0 or column 0: window reaches outside the frame
                s1_border <= (h_pos == 10'd1) || (v_pos == 9'd1);
                s1_h      <= h_pos - 10'd1;
                s1_v      <= v_pos - 9'd1;
            end
        end
    end

    // Weighted column/row sums (max 1020) and their differences as 11-bit two's complement
    assign sum_l = {2'b00, win_top[0]} + {1'b0, win_mid[0], 1'b0} + {2'b00, win_bot[0]};
    assign sum_r = {2'b00, win_top[2]} + {1'b0, win_mid[2], 1'b0} + {2'b00, win_bot[2]};
    assign sum_t = {2'b00, win_top[0]} + {1'b0, win_top[1], 1'b0} + {2'b00, win_top[2]};
    assign sum_b = {2'b00, win_bot[0]} + {1'b0, win_bot[1], 1'b0} + {2'b00, win_bot[2]};
    assign gx_c  = {1'b0, sum_r} - {1'b0, sum_l};
    assign gy_c  = {1'b0, sum_b} - {1'b0, sum_t};

    // Gradient stage register
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld    <= 1'b0;
            s2_byp    <= 1'b0;
            s2_border <= 1'b0;
            s2_h      <= 10'd0;
            s2_v      <= 9'd0;
            s2_ctr    <= 8'd0;
            s2_gx     <= 11'd0;
            s2_gy     <= 11'd0;
        end else begin
            s2_vld    <= s1_vld;
            s2_byp    <= s1_byp;
            s2_border <= s1_border;
            s2_h      <= s1_h;
            s2_v      <= s1_v;
            s2_ctr    <= win_mid[1];
            s2_gx     <= gx_c;
            s2_gy     <= gy_c;
        end
    end

    // Absolute values fit in 10 bits; their sum (max 2040) fits in 11
    assign abs_gx = s2_gx[10] ? (~s2_gx + 11'd1) : s2_gx;
    assign abs_gy = s2_gy[10] ? (~s2_gy + 11'd1) : s2_gy;
    assign mag_c  = abs_gx + abs_gy;

    // Magnitude stage register
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld    <= 1'b0;
            s3_byp    <= 1'b0;
            s3_border <= 1'b0;
            s3_h      <= 10'd0;
            s3_v      <= 9'd0;
            s3_ctr    <= 8'd0;
            s3_mag    <= 11'd0;
        end else begin
            s3_vld    <= s2_vld;
            s3_byp    <= s2_byp;
            s3_border <= s2_border;
            s3_h      <= s2_h;
            s3_v      <= s2_v;
            s3_ctr    <= s2_ctr;
            s3_mag    <= mag_c;
        end
    end

    // Result select: bypass wins, then border zero, then threshold (on raw magnitude) or saturation
    always_comb begin
        res_c = 8'd0;
        if (s3_byp) begin
            res_c = s3_ctr;
        end else if (s3_border) begin
            res_c = 8'd0;
        end else if (THR_EN) begin
            res_c = ({1'b0, s3_mag} >= THR) ? 8'hFF : 8'h00;
        end else if (s3_mag > 11'd255) begin
            res_c = 8'hFF;
        end else begin
            res_c = s3_mag[7:0];
        end
    end

    // Output register; position and data only move when a result is emitted
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_h     <= 10'd0;
            out_v     <= 9'd0;
            edge_out  <= 8'd0;
        end else begin
            out_valid <= s3_vld;
            if (s3_vld) begin
                out_h    <= s3_h;
                out_v    <= s3_v;
                edge_out <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Bench for sobel_edge_filter on a reduced 16x10 frame, three threshold variants in parallel.
// Latency: expected results are due exactly 3 cycles after the completing sample's sampling edge.
// Backpressure: none; the stream includes horizontal and vertical blanking cycles.
module tb_sobel_edge_filter;
    localparam int H  = 16;
    localparam int V  = 10;
    localparam int HB = 3;

    logic       pixel_clk = 1'b0;
    logic       rst_n     = 1'b0;
    logic [9:0] h_pos;
    logic [8:0] v_pos;
    logic [7:0] pix_in;
    logic       bypass;

    logic       out_valid, t40_valid, t50_valid;
    logic [9:0] out_h, t40_h, t50_h;
    logic [8:0] out_v, t40_v, t50_v;
    logic [7:0] edge_out, t40_edge, t50_edge;

    typedef struct {
        int cyc;
        int h;
        int v;
        int raw;
        int t40;
        int t50;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] img [V][H];
    int         out_img [V][H];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_emit   = 0;
    bit         m_sync   = 1'b0;

    sobel_edge_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESHOLD(0)) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .h_pos(h_pos), .v_pos(v_pos),
        .pix_in(pix_in), .bypass(bypass), .out_valid(out_valid), .out_h(out_h),
        .out_v(out_v), .edge_out(edge_out)
    );

    sobel_edge_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESHOLD(40)) dut_t40 (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .h_pos(h_pos), .v_pos(v_pos),
        .pix_in(pix_in), .bypass(bypass), .out_valid(t40_valid), .out_h(t40_h),
        .out_v(t40_v), .edge_out(t40_edge)
    );

    sobel_edge_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESHOLD(50)) dut_t50 (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .h_pos(h_pos), .v_pos(v_pos),
        .pix_in(pix_in), .bypass(bypass), .out_valid(t50_valid), .out_h(t50_h),
        .out_v(t50_v), .edge_out(t50_edge)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    function automatic int px(input int c, input int r);
        return int'(img[r][c]);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Reference model: expected result for centre (x,y) from the frame image
    task automatic push_expect(input int x, input int y, input logic byp);
        exp_t e;
        int   gx, gy, mag;
        e.cyc = cyc + 4;
        e.h   = x;
        e.v   = y;
        if (byp) begin
            e.raw = px(x, y);
            e.t40 = e.raw;
            e.t50 = e.raw;
        end else if (x == 0 || y == 0) begin
            e.raw = 0;
            e.t40 = 0;
            e.t50 = 0;
        end else begin
            gx = (px(x+1, y-1) + 2 * px(x+1, y) + px(x+1, y+1))
               - (px(x-1, y-1) + 2 * px(x-1, y) + px(x-1, y+1));
            gy = (px(x-1, y+1) + 2 * px(x, y+1) + px(x+1, y+1))
               - (px(x-1, y-1) + 2 * px(x, y-1) + px(x+1, y-1));
            mag   = iabs(gx) + iabs(gy);
            e.raw = (mag > 255) ? 255 : mag;
            e.t40 = (mag >= 40) ? 255 : 0;
            e.t50 = (mag >= 50) ? 255 : 0;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input int h, input int v, input logic [7:0] p, input logic byp);
        @(posedge pixel_clk);
        #1;
        h_pos  = 10'(h);
        v_pos  = 9'(v);
        pix_in = p;
        bypass = byp;
        if (h < H && v < V) begin
            if (m_sync && h >= 1 && v >= 1) push_expect(h - 1, v - 1, byp);
            if (h == 0 && v == 0) m_sync = 1'b1;
        end
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                case (mode)
                    0:       img[r][c] = 8'd100;
                    1:       img[r][c] = (c >= 8) ? 8'd200 : 8'd0;
                    2:       img[r][c] = (c >= 8) ? 8'd10 : 8'd0;
                    3:       img[r][c] = (r >= 5) ? 8'd30 : 8'd0;
                    4:       img[r][c] = 8'(c);
                    default: img[r][c] = 8'($urandom);
                endcase
                out_img[r][c] = -1;
            end
        end
    endtask

    task automatic mid_reset();
        #2;
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_h", out_h, 0);
        chk("mid_rst_v", out_v, 0);
        chk("mid_rst_edge", edge_out, 0);
        sb.delete();
        m_sync = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // byp_mode: 0 off, 1 on, 2 toggles with position; rst_row < 0 means no mid-frame reset
    task automatic run_frame(input int v_start, input int byp_mode, input int rst_row);
        n_emit = 0;
        for (int v = v_start; v <= V; v++) begin
            for (int h = 0; h < H + HB; h++) begin
                logic [7:0] p;
                logic       b;
                p = (h < H && v < V) ? img[v][h] : 8'($urandom);
                b = (byp_mode == 2) ? (h[1] ^ v[0]) : byp_mode[0];
                drive(h, v, p, b);
                if (v == rst_row && h == 5) mid_reset();
            end
        end
        repeat (6) @(posedge pixel_clk);
        #1;
    endtask

    // Scoreboard: each due result must appear on its exact cycle; nothing else may be valid
    always @(negedge pixel_clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("valid", out_valid, 1);
            chk("t40_valid", t40_valid, 1);
            chk("t50_valid", t50_valid, 1);
            chk("out_h", out_h, mon_e.h);
            chk("out_v", out_v, mon_e.v);
            chk("edge_raw", edge_out, mon_e.raw);
            chk("edge_t40", t40_edge, mon_e.t40);
            chk("edge_t50", t50_edge, mon_e.t50);
            out_img[mon_e.v][mon_e.h] = int'(edge_out);
            n_emit++;
        end else if ({out_valid, t40_valid, t50_valid} !== 3'b000) begin
            chk("spurious_valid", {29'd0, out_valid, t40_valid, t50_valid}, 0);
        end
    end

    initial begin
        h_pos  = 10'(H);
        v_pos  = 9'(V);
        pix_in = 8'd0;
        bypass = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_h", out_h, 0);
        chk("reset_v", out_v, 0);
        chk("reset_edge", edge_out, 0);
        rst_n = 1'b1;

        // Stream joins mid-frame: nothing may be emitted before the next frame start
        fill(5);
        run_frame(4, 0, -1);
        chk("unsynced_count", n_emit, 0);

        fill(0);
        run_frame(0, 0, -1);
        chk("uniform_count", n_emit, (H - 1) * (V - 1));
        chk("uniform_5_7", out_img[5][7], 0);

        fill(1);
        run_frame(0, 0, -1);
        chk("vstep200_3_7", out_img[3][7], 255);
        chk("vstep200_3_8", out_img[3][8], 255);
        chk("vstep200_3_6", out_img[3][6], 0);
        chk("vstep200_3_9", out_img[3][9], 0);
        chk("vstep200_row0", out_img[0][7], 0);

        fill(2);
        run_frame(0, 0, -1);
        chk("vstep10_4_7", out_img[4][7], 40);
        chk("vstep10_4_8", out_img[4][8], 40);

        fill(3);
        run_frame(0, 0, -1);
        chk("hstep_4_3", out_img[4][3], 120);
        chk("hstep_5_3", out_img[5][3], 120);
        chk("hstep_3_3", out_img[3][3], 0);
        chk("hstep_col0", out_img[4][0], 0);

        fill(4);
        run_frame(0, 1, -1);
        chk("bypass_6_9", out_img[6][9], 9);
        chk("bypass_row0", out_img[0][5], 5);
        chk("bypass_count", n_emit, (H - 1) * (V - 1));

        fill(5);
        run_frame(0, 2, -1);
        chk("toggle_count", n_emit, (H - 1) * (V - 1));

        fill(5);
        run_frame(0, 0, 4);

        fill(5);
        run_frame(0, 0, -1);
        chk("resume_count", n_emit, (H - 1) * (V - 1));

        repeat (4) @(posedge pixel_clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sobel_edge_filter.md
Name: sobel_edge_filter

Overview:
- Streaming 3x3 Sobel edge detector directly downstream of the frame buffer in the HDMI edge-detection path.
- Consumes the 8-bit grayscale raster stream (pixel plus its display position) in the pixel clock domain.
- Uses two line buffers and a 3x3 window to produce a saturated |Gx|+|Gy| magnitude per pixel, optionally thresholded, tagged with its own position for the HDMI encoder stage.
- A bypass mode passes the centre pixel through unchanged, with identical latency.

Parameters:
H_ACTIVE, 640, active pixels per line; line buffer depth
V_ACTIVE, 480, active lines per frame
THRESHOLD, 0, 0 = output raw magnitude; >0 = output 255 if magnitude >= THRESHOLD, else 0

Ports:
pixel_clk  in  1  pixel clock; all logic on its rising edge
rst_n  in  1  reset, asynchronous, active-low
h_pos  in  10  horizontal position of pix_in; active when < H_ACTIVE
v_pos  in  9  vertical position of pix_in; active when < V_ACTIVE
pix_in  in  8  grayscale pixel at (h_pos, v_pos); upstream aligns it with its position
bypass  in  1  1 = output the window centre pixel instead of the magnitude; sampled with the input
out_valid  out  1  edge_out/out_h/out_v valid this cycle
out_h  out  10  column of the centre pixel for edge_out
out_v  out  9  row of the centre pixel for edge_out
edge_out  out  8  edge magnitude, thresholded value or bypass pixel

Behaviour:
- Clock and reset: one clock (pixel_clk). Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_h=0, out_v=0, edge_out=0. All pipeline valid flags and window registers are cleared. Line-buffer contents are undefined after reset.
- Active sample: h_pos<H_ACTIVE and v_pos<V_ACTIVE.
  - Writes pix_in into the line buffers at column h_pos.
  - Shifts the window one column.
  - Non-active cycles write nothing, do not shift the window, and produce out_valid=0 at the output, L cycles later.
- Window: rows v_pos-2, v_pos-1, v_pos; columns h_pos-2..h_pos.
  - The sample at (x+1,y+1) completes the window centred on (x,y).
- Emission:
  - Each active sample with h_pos>=1 and v_pos>=1 emits one result with out_h=h_pos-1 and out_v=v_pos-1.
  - Samples with h_pos==0 or v_pos==0 emit nothing.
  - Consequence: column H_ACTIVE-1 and row V_ACTIVE-1 are never emitted.
  - Downstream shifts display by (1,1) and blanks the missing column and row.
- Border: centres with out_h==0 or out_v==0 emit edge_out=0. In bypass mode they emit the centre pixel.
- Arithmetic:
  - Gx = (p02+2*p12+p22)-(p00+2*p10+p20)
  - Gy = (p20+2*p21+p22)-(p00+2*p01+p02)
  - Gx and Gy are signed 11-bit (range ±1020).
  - mag = |Gx|+|Gy|, unsigned 11-bit (max 2040), saturated to 255.
  - When THRESHOLD>0, the output is binarised after saturation; the comparison uses the unsaturated mag.
- Latency: fixed L=3 pixel_clk cycles from the sampling edge of the completing input to out_valid/edge_out. Constant in every mode.
- Frame sync:
  - After reset, out_valid stays 0 until the first sample with h_pos==0 and v_pos==0 (the next frame start).
  - From then on, emission runs normally. This prevents garbage line-buffer contents from reaching the output.
- Stalled positions: if h_pos/v_pos hold or skip values, the block has no flow control and processes each cycle's sample as given.
- Mid-operation reset: all outputs are forced to reset values immediately (asynchronously). The frame-sync rule then applies.
- bypass may change on any cycle; it affects only results whose completing sample saw the new value.

Test Plan:
- Uniform frame, all pixels 100, bypass=0, THRESHOLD=0 -> every emitted edge_out=0; exactly (H_ACTIVE-1)*(V_ACTIVE-1) out_valid pulses per frame after the first frame start.
- Vertical step, columns<320 =0 and >=320 =200 -> edge_out=255 at out_h=319 and 320 (mag 800 saturated); 0 at out_h=318 and 321 for rows 1..478.
- Vertical step 0/10 -> edge_out=40 at out_h=319 and 320; same stimulus with THRESHOLD=50 -> 0; with THRESHOLD=40 -> 255.
- Horizontal step, rows<240 =0 and >=240 =30 -> edge_out=120 at out_v=239 and 240; 0 elsewhere; row 0 and column 0 always 0.
- bypass=1, ramp pix = h_pos[7:0] -> edge_out at (x,y) equals x[7:0], arriving exactly 3 cycles after sample (x+1,y+1).
- rst_n pulsed low mid-frame at v_pos=100 -> outputs 0 immediately; out_valid stays 0 through the rest of that frame; correct results resume from the next frame's (1,1) sample.
